bist_lfsr_misr: RTL
===================

# bist_lfsr_misr

Parametrised built-in self-test engine for the combinational benchmark netlists (c432-class). A Fibonacci LFSR pattern generator (PRPG) drives the netlist inputs, and a multiple-input signature register (MISR) compacts its outputs. A cycle-level `hold` input freezes all state, acting as a data-driven clock enable in the style of the gated-register experiments. It sits between the benchmark netlist and the test controller, and reports `done`/`pass` against a golden signature.

## Interface
Parameters:
- `PRPG_W`, 36: pattern width; equals the number of netlist inputs.
- `PRPG_POLY`, 36'h8_0000_0400: feedback tap mask (x^36+x^11+1). Bit i set means state bit i feeds the XOR.
- `SEED`, 36'h0_0000_0001: reset and lock-up-replacement seed; must be non-zero.
- `MISR_W`, 7: response width; equals the number of netlist outputs.
- `MISR_POLY`, 7'h60: MISR tap mask (x^7+x^6+1).
- `N_PAT`, 1024: patterns per run; N_PAT ≥ 1.
- `GOLDEN`, 7'h00: expected signature.
- `CNT_W`, $clog2(N_PAT+1): counter width.

Ports:
- `clk`, in, 1: single clock; every register updates on the rising edge.
- `reset`, in, 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `start`, in, 1: begin a run. Honoured in IDLE and DONE only.
- `seed_load`, in, 1: load `seed_in`. Honoured in IDLE and DONE only.
- `seed_in`, in, PRPG_W: new seed.
- `hold`, in, 1: freeze PRPG, MISR and counter during RUN.
- `resp`, in, MISR_W: netlist response to the current `pattern`, sampled in the same cycle.
- `pattern`, out, PRPG_W: current PRPG state, driven straight from the register.
- `signature`, out, MISR_W: current MISR state.
- `pat_count`, out, CNT_W: number of patterns compacted so far.
- `busy`, out, 1: state == RUN.
- `done`, out, 1: state == DONE.
- `pass`, out, 1: done && (signature == GOLDEN); 0 otherwise.

## Operation
- FSM states are IDLE, RUN and DONE.
- Reset (reset==0 at an edge):
  - state ← IDLE.
  - prpg ← SEED; seed_reg ← SEED.
  - misr ← 0; cnt ← 0.
  - Resulting outputs: busy=0, done=0, pass=0, pattern=SEED, signature=0, pat_count=0.
- Reset overrides everything. Reset during RUN aborts the run with no residual state.
- Seed load (IDLE or DONE):
  - `seed_load`=1 sets seed_reg ← (seed_in==0 ? SEED : seed_in) and sets prpg to the same value.
  - In RUN, `seed_load` is ignored.
- Start (IDLE or DONE, `start`=1):
  - state ← RUN; misr ← 0; cnt ← 0.
  - prpg ← seed_reg, or ← the effective `seed_in` if `seed_load` is asserted in the same cycle (the new seed wins).
  - In RUN, `start` is ignored.
- RUN, edge with hold=0:
  - PRPG: fb = ^(prpg & PRPG_POLY); prpg ← {prpg[PRPG_W-2:0], fb}.
  - MISR: mf = ^(misr & MISR_POLY); misr[0] ← mf ^ resp[0]; misr[i] ← misr[i-1] ^ resp[i] for i ≥ 1.
  - cnt ← cnt+1.
  - If cnt == N_PAT-1 before the edge, state ← DONE.
- RUN, edge with hold=1: prpg, misr, cnt and state all hold. `resp` is not sampled.
- DONE: all registers hold. `pass` is combinational from signature vs GOLDEN, qualified by done.
- All arithmetic is unsigned. cnt never exceeds N_PAT, and no wrap is reachable.
- The PRPG never enters the all-zero state, because the seed path substitutes SEED for zero.

## Timing
- `start` sampled at edge k (hold low throughout):
  - busy=1 after edge k, and pattern=seed.
  - Pattern j (j=0..N_PAT-1) is presented during the cycle after edge k+j and compacted at edge k+j+1.
  - done=1 after edge k+N_PAT. Total latency is N_PAT+1 edges from start to done.
- Each hold cycle extends the run by exactly one cycle.
- Outputs are registered, except `pass` (one AND/compare level after registers) and `busy`/`done` (state decode only).
- The netlist path pattern → resp must close in one clock period.
- Restart from DONE is back-to-back: `start` at the edge leaving DONE puts busy=1 in the very next cycle.

## Test plan
- Reset: hold reset=0 for 2 cycles with start=1 → busy=0, done=0, pass=0, pattern=36'h0_0000_0001, signature=0, pat_count=0.
- PRPG sequence: seed 36'h1, start, hold=0 → pattern equals 1<<j for j=0..10, and 36'h0_0000_0801 after 11 advances.
- Zero seed: seed_load with seed_in=0 in IDLE → pattern=SEED. seed_load during RUN → pattern sequence unchanged.
- MISR/pass: N_PAT=3, GOLDEN=7'h07, resp=7'h01 constant, start → signature 01, 03, 07; done=1 after edge k+3; pass=1. Repeat with GOLDEN=7'h06 → pass=0.
- Hold: N_PAT=3, assert hold for 2 cycles mid-run → pattern, signature and pat_count frozen during hold; done arrives 2 cycles late; signature still 7'h07.
- Abort/restart: reset=0 at pat_count=5 → all outputs return to reset values. Then start again → run completes normally. start during RUN → ignored, pat_count continues.

Source files
------------

// File: rtl/bist_lfsr_misr.sv
// bist_lfsr_misr: Fibonacci LFSR pattern generator plus MISR response compactor
// for combinational netlist self-test, with hold-to-freeze and golden signature compare.
module bist_lfsr_misr #(
    parameter int                PRPG_W    = 36,
    parameter logic [PRPG_W-1:0] PRPG_POLY = 36'h8_0000_0400,
    parameter logic [PRPG_W-1:0] SEED      = 36'h0_0000_0001,
    parameter int                MISR_W    = 7,
    parameter logic [MISR_W-1:0] MISR_POLY = 7'h60,
    parameter int                N_PAT     = 1024,
    parameter logic [MISR_W-1:0] GOLDEN    = 7'h00,
    parameter int                CNT_W     = $clog2(N_PAT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              seed_load,
    input  logic [PRPG_W-1:0] seed_in,
    input  logic              hold,
    input  logic [MISR_W-1:0] resp,
    output logic [PRPG_W-1:0] pattern,
    output logic [MISR_W-1:0] signature,
    output logic [CNT_W-1:0]  pat_count,
    output logic              busy,
    output logic              done,
    output logic              pass
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [PRPG_W-1:0] prpg, prpg_nx, seed_reg, seed_eff;
    logic [MISR_W-1:0] misr, misr_nx;
    logic [CNT_W-1:0]  cnt;
    logic              ctl, adv, last;

    assign ctl      = state != RUN;
    assign adv      = state == RUN && !hold;
    assign last     = cnt == CNT_W'(N_PAT - 1);
    // A zero seed would lock the LFSR up, so it is replaced by SEED
    assign seed_eff = seed_in == '0 ? SEED : seed_in;
    assign prpg_nx  = {prpg[PRPG_W-2:0], ^(prpg & PRPG_POLY)};
    assign misr_nx  = {misr[MISR_W-2:0], ^(misr & MISR_POLY)} ^ resp;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (ctl && start)     state_nx = RUN;
        else if (adv && last) state_nx = DONE;
    end

    always_comb begin
        busy = state == RUN;
        done = state == DONE;
        pass = done && signature == GOLDEN;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prpg     <= SEED;
            seed_reg <= SEED;
            misr     <= '0;
            cnt      <= '0;
        end else if (ctl) begin
            if (seed_load) begin
                seed_reg <= seed_eff;
                prpg     <= seed_eff;
            end
            if (start) begin
                misr <= '0;
                cnt  <= '0;
                prpg <= seed_load ? seed_eff : seed_reg;
            end
        end else if (!hold) begin
            prpg <= prpg_nx;
            misr <= misr_nx;
            cnt  <= cnt + CNT_W'(1);
        end
    end

    assign pattern   = prpg;
    assign signature = misr;
    assign pat_count = cnt;
endmodule
